// File: rtl/ax_btb_update_scheduler_if.sv
// Signal bundle between BTB update requesters, the update scheduler and the BTB RAM write ports.
interface ax_btb_update_scheduler_if #(
  parameter int WRITE_NUM  = 2,
  parameter int INDEX_BITS = 9,
  parameter int ENTRY_BITS = 32
);
  logic                            flush;
  logic [WRITE_NUM-1:0]            reqValid;
  logic [WRITE_NUM*INDEX_BITS-1:0] reqIndex;
  logic [WRITE_NUM*ENTRY_BITS-1:0] reqData;
  logic [WRITE_NUM-1:0]            ramWE;
  logic [WRITE_NUM*INDEX_BITS-1:0] ramWA;
  logic [WRITE_NUM*ENTRY_BITS-1:0] ramWV;
  logic                            initBusy;
  logic                            queueFull;
  logic [15:0]                     dropCount;

  modport master (
    output flush, reqValid, reqIndex, reqData,
    input  ramWE, ramWA, ramWV, initBusy, queueFull, dropCount
  );
  modport slave (
    input  flush, reqValid, reqIndex, reqData,
    output ramWE, ramWA, ramWV, initBusy, queueFull, dropCount
  );
endinterface

// File: rtl/ax_btb_update_scheduler.sv
// Schedules BTB updates onto banked RAM write ports: invalidation sweep after reset/flush,
// direct grants for bank-disjoint requests, and a small FIFO that replays bank conflicts later.
module ax_btb_update_scheduler #(
  parameter int WRITE_NUM   = 2,
  parameter int BANK_NUM    = 2,
  parameter int INDEX_BITS  = 9,
  parameter int ENTRY_BITS  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ax_btb_update_scheduler_if.slave bus
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [INDEX_BITS-1:0] BANK_MASK  = INDEX_BITS'(BANK_NUM - 1);
  localparam logic [INDEX_BITS-1:0] SWEEP_LAST = {INDEX_BITS{1'b1}};
  localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [INDEX_BITS-1:0] qidx_q [QUEUE_DEPTH];
  logic [INDEX_BITS-1:0] qidx_d [QUEUE_DEPTH];
  logic [ENTRY_BITS-1:0] qdat_q [QUEUE_DEPTH];
  logic [ENTRY_BITS-1:0] qdat_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic [15:0]           drop_q, drop_d;

  logic [INDEX_BITS-1:0]           req_idx_s [WRITE_NUM];
  logic [ENTRY_BITS-1:0]           req_dat_s [WRITE_NUM];
  logic                            run_s;
  logic [WRITE_NUM-1:0]            grant_s;
  logic [WRITE_NUM-1:0]            blocked_s;
  logic [WRITE_NUM-1:0]            we_s;
  logic [WRITE_NUM*INDEX_BITS-1:0] wa_s;
  logic [WRITE_NUM*ENTRY_BITS-1:0] wv_s;
  logic                            push_s;
  logic                            pop_s;
  logic                            head_ok_s;
  logic [INDEX_BITS-1:0]           push_idx_s;
  logic [ENTRY_BITS-1:0]           push_dat_s;
  logic [16:0]                     drop_sum_s;

  function automatic logic same_bank(input logic [INDEX_BITS-1:0] a,
                                     input logic [INDEX_BITS-1:0] b);
    return (a & BANK_MASK) == (b & BANK_MASK);
  endfunction

  // Requests are ignored while sweeping, in reset, and in the flush cycle itself.
  assign run_s = (state_q == ST_RUN) && !bus.flush && !rst;

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < WRITE_NUM; i++) begin
      req_idx_s[i] = bus.reqIndex[i*INDEX_BITS +: INDEX_BITS];
      req_dat_s[i] = bus.reqData[i*ENTRY_BITS +: ENTRY_BITS];
    end
  end

  // Priority bank arbitration: direct grants, one conflict push, and drop accounting.
  always_comb begin
    grant_s    = '0;
    blocked_s  = '0;
    push_s     = 1'b0;
    push_idx_s = '0;
    push_dat_s = '0;
    drop_sum_s = {1'b0, drop_q};
    for (int i = 0; i < WRITE_NUM; i++) begin
      for (int j = 0; j < i; j++) begin
        blocked_s[i] = blocked_s[i] | (grant_s[j] & same_bank(req_idx_s[i], req_idx_s[j]));
      end
      if (!run_s || !bus.reqValid[i]) begin
        grant_s[i] = 1'b0;
      end else if (!blocked_s[i]) begin
        grant_s[i] = 1'b1;
      end else if (!push_s && !full_q) begin
        push_s     = 1'b1;
        push_idx_s = req_idx_s[i];
        push_dat_s = req_dat_s[i];
      end else begin
        drop_sum_s = drop_sum_s + 17'd1;
      end
    end
  end

  // RAM write port muxing: sweep in INIT, otherwise direct grants plus at most one queue pop.
  always_comb begin
    we_s      = '0;
    wa_s      = '0;
    wv_s      = '0;
    pop_s     = 1'b0;
    head_ok_s = run_s && (count_q != '0);
    for (int j = 0; j < WRITE_NUM; j++) begin
      head_ok_s = head_ok_s & ~(grant_s[j] & same_bank(qidx_q[rd_ptr_q], req_idx_s[j]));
    end
    if (rst) begin
      we_s = '0;
    end else if (state_q == ST_INIT) begin
      we_s[0]              = 1'b1;
      wa_s[INDEX_BITS-1:0] = sweep_q;
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (grant_s[i]) begin
          we_s[i]                          = 1'b1;
          wa_s[i*INDEX_BITS +: INDEX_BITS] = req_idx_s[i];
          wv_s[i*ENTRY_BITS +: ENTRY_BITS] = req_dat_s[i];
        end else if (head_ok_s && !pop_s) begin
          pop_s                            = 1'b1;
          we_s[i]                          = 1'b1;
          wa_s[i*INDEX_BITS +: INDEX_BITS] = qidx_q[rd_ptr_q];
          wv_s[i*ENTRY_BITS +: ENTRY_BITS] = qdat_q[rd_ptr_q];
        end else begin
          we_s[i] = 1'b0;
        end
      end
    end
  end

  // Next-state: FSM, sweep counter, conflict FIFO and saturating drop counter.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    qidx_d   = qidx_q;
    qdat_d   = qdat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    if (bus.flush) begin
      state_d  = ST_INIT;
      sweep_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (state_q == ST_INIT) begin
      state_d = (sweep_q == SWEEP_LAST) ? ST_RUN : ST_INIT;
      sweep_d = sweep_q + INDEX_BITS'(1);
    end else begin
      if (push_s) begin
        qidx_d[wr_ptr_q] = push_idx_s;
        qdat_d[wr_ptr_q] = push_dat_s;
        wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
    full_d = (count_d == CNT_FULL);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO payload storage; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    qidx_q <= qidx_d;
    qdat_q <= qdat_d;
  end

  assign bus.ramWE     = we_s;
  assign bus.ramWA     = wa_s;
  assign bus.ramWV     = wv_s;
  assign bus.initBusy  = (state_q == ST_INIT);
  assign bus.queueFull = full_q;
  assign bus.dropCount = drop_q;
endmodule
